// File: rtl/rtc_bus_pkg.sv
// Shared types and timing constants for the RTC bus sequencer.
package rtc_bus_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ADDR    = 3'd1,
        DATA_WR = 3'd2,
        DATA_RD = 3'd3,
        RECOV   = 3'd4
    } state_e;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_e;

    localparam int STROBE_START      = 4;
    localparam int STROBE_END_MARGIN = 4;
    localparam int RECOV_LEN         = 4;

    // True when a phase counter value lies in the strobe window of a phase
    // that is phase_len cycles long.
    function automatic logic in_window(input logic [4:0] c, input int phase_len);
        return (int'(c) >= STROBE_START) &&
               (int'(c) <= phase_len - 1 - STROBE_END_MARGIN);
    endfunction

endpackage

// File: rtl/rtc_phase_counter.sv
// 5-bit phase timer: clears on request, counts up while enabled and holds
// once it reaches the limit, flagging that final cycle with last.
module rtc_phase_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic [4:0] limit,
    output logic [4:0] cnt,
    output logic       last
);

    assign last = (cnt == limit);

    // Clear has priority over counting; the count never runs past the limit.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= 5'd0;
        end else if (clr) begin
            cnt <= 5'd0;
        end else if (en && (cnt < limit)) begin
            cnt <= cnt + 5'd1;
        end
    end

endmodule

// File: rtl/rtc_bus_sequencer.sv
// Sequencer for the multiplexed RTC address/data bus. Each request runs an
// address phase, a write or read data phase and a short recovery gap; a
// write+read request pair chains a read-back of the same address.
// PHASE_LEN must stay within 12..31 and RD_SAMPLE inside the strobe window.
module rtc_bus_sequencer
    import rtc_bus_pkg::*;
#(
    parameter int PHASE_LEN = 24,
    parameter int RD_SAMPLE = 18
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_wr,
    input  logic       req_rd,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    input  logic [7:0] ad_in,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    output logic       a_d,
    output logic       cs_n,
    output logic       rd_n,
    output logic       wr_n,
    output logic [7:0] rdata,
    output logic       busy,
    output logic       done
);

    localparam logic [4:0] PHASE_LAST = 5'(PHASE_LEN - 1);
    localparam logic [4:0] RECOV_LAST = 5'(RECOV_LEN - 1);
    localparam logic [4:0] SAMPLE_AT  = 5'(RD_SAMPLE);

    state_e     state;
    op_e        op;
    logic       rd_pending;
    logic [7:0] lat_addr;
    logic [7:0] lat_wdata;

    logic [4:0] cnt;
    logic [4:0] cnt_limit;
    logic       cnt_last;
    logic       cnt_clr;
    logic       win_next;

    // The counter restarts whenever the state is about to change (or idles);
    // win_next predicts whether the coming cycle is inside the strobe window
    // so the registered strobes line up exactly with the counter.
    always_comb begin
        cnt_limit = (state == RECOV) ? RECOV_LAST : PHASE_LAST;
        cnt_clr   = (state == IDLE) || cnt_last;
        win_next  = !cnt_clr && in_window(cnt + 5'd1, PHASE_LEN);
    end

    rtc_phase_counter u_phase_counter (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .en    (1'b1),
        .limit (cnt_limit),
        .cnt   (cnt),
        .last  (cnt_last)
    );

    // Bus FSM with every pad-facing output registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            op         <= OP_RD;
            rd_pending <= 1'b0;
            lat_addr   <= 8'd0;
            lat_wdata  <= 8'd0;
            ad_out     <= 8'd0;
            ad_oe      <= 1'b0;
            a_d        <= 1'b1;
            cs_n       <= 1'b1;
            rd_n       <= 1'b1;
            wr_n       <= 1'b1;
            rdata      <= 8'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            cs_n <= 1'b1;
            rd_n <= 1'b1;
            wr_n <= 1'b1;
            case (state)
                IDLE: begin
                    if (req_wr || req_rd) begin
                        lat_addr   <= addr;
                        lat_wdata  <= wdata;
                        op         <= req_wr ? OP_WR : OP_RD;
                        rd_pending <= req_wr && req_rd;
                        state      <= ADDR;
                        busy       <= 1'b1;
                        a_d        <= 1'b0;
                        ad_oe      <= 1'b1;
                        ad_out     <= addr;
                    end
                end
                ADDR: begin
                    cs_n <= !win_next;
                    wr_n <= !win_next;
                    if (cnt_last) begin
                        a_d <= 1'b1;
                        if (op == OP_WR) begin
                            state  <= DATA_WR;
                            ad_oe  <= 1'b1;
                            ad_out <= lat_wdata;
                        end else begin
                            state  <= DATA_RD;
                            ad_oe  <= 1'b0;
                            ad_out <= 8'd0;
                        end
                    end
                end
                DATA_WR: begin
                    cs_n <= !win_next;
                    wr_n <= !win_next;
                    if (cnt_last) begin
                        state  <= RECOV;
                        ad_oe  <= 1'b0;
                        ad_out <= 8'd0;
                    end
                end
                DATA_RD: begin
                    cs_n <= !win_next;
                    rd_n <= !win_next;
                    if (cnt == SAMPLE_AT) begin
                        rdata <= ad_in;
                    end
                    if (cnt_last) begin
                        state <= RECOV;
                    end
                end
                RECOV: begin
                    if (cnt_last) begin
                        done <= 1'b1;
                        if (rd_pending) begin
                            rd_pending <= 1'b0;
                            op         <= OP_RD;
                            state      <= ADDR;
                            a_d        <= 1'b0;
                            ad_oe      <= 1'b1;
                            ad_out     <= lat_addr;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Scoreboard bench for rtc_bus_sequencer: the stimulus side predicts each
// transaction from the bus timing rules, the monitor checks every done pulse
// and the bus activity observed since the previous one.
module tb_rtc_bus_sequencer;

    localparam int PL      = 24;
    localparam int RS      = 18;
    localparam int RL      = 4;
    localparam int SS      = 4;
    localparam int SW      = PL - 2 * SS;
    localparam int TXN_LEN = 2 * PL + RL;
    localparam int HIST    = 8192;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_wr = 1'b0;
    logic       req_rd = 1'b0;
    logic [7:0] addr = 8'd0;
    logic [7:0] wdata = 8'd0;
    logic [7:0] ad_in = 8'd0;
    logic [7:0] ad_out;
    logic       ad_oe;
    logic       a_d;
    logic       cs_n;
    logic       rd_n;
    logic       wr_n;
    logic [7:0] rdata;
    logic       busy;
    logic       done;

    rtc_bus_sequencer #(.PHASE_LEN(PL), .RD_SAMPLE(RS)) dut (
        .clk    (clk),
        .rst    (rst),
        .req_wr (req_wr),
        .req_rd (req_rd),
        .addr   (addr),
        .wdata  (wdata),
        .ad_in  (ad_in),
        .ad_out (ad_out),
        .ad_oe  (ad_oe),
        .a_d    (a_d),
        .cs_n   (cs_n),
        .rd_n   (rd_n),
        .wr_n   (wr_n),
        .rdata  (rdata),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         e0;
        int         done_cyc;
        bit         is_wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] rdata;
        bit         busy_after;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] ad_hist [HIST];
    int         checks = 0;
    int         passes = 0;
    int         idle_cyc = 0;
    logic [7:0] last_rd = 8'd0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d",
                      name, actual, expected, cyc);
    endtask

    // Issue one request cycle and predict its outcome: a request is taken
    // only when the bus is idle at the sampling edge; a write+read pair
    // becomes a write followed immediately by a read of the same address.
    task automatic applyStimulus(input bit wr, input bit rd,
                                 input logic [7:0] a, input logic [7:0] d);
        int   n;
        int   e0;
        bit   accepted;
        exp_t e;
        n        = cyc;
        accepted = 1'b0;
        req_wr   = wr;
        req_rd   = rd;
        addr     = a;
        wdata    = d;
        if ((wr || rd) && n >= idle_cyc) begin
            accepted = 1'b1;
            e0       = n + 1;
            e.e0     = e0;
            e.addr   = a;
            e.wdata  = d;
            e.is_wr  = wr;
            e.done_cyc = e0 + TXN_LEN;
            if (wr) begin
                e.rdata      = last_rd;
                e.busy_after = rd;
                exp_q.push_back(e);
                idle_cyc = e.done_cyc;
                if (rd) begin
                    e0           = e0 + TXN_LEN;
                    e.e0         = e0;
                    e.is_wr      = 1'b0;
                    e.done_cyc   = e0 + TXN_LEN;
                    last_rd      = ad_hist[(e0 + PL + RS) % HIST];
                    e.rdata      = last_rd;
                    e.busy_after = 1'b0;
                    exp_q.push_back(e);
                    idle_cyc = e.done_cyc;
                end
            end else begin
                last_rd      = ad_hist[(e0 + PL + RS) % HIST];
                e.rdata      = last_rd;
                e.busy_after = 1'b0;
                exp_q.push_back(e);
                idle_cyc = e.done_cyc;
            end
        end
        @(negedge clk);
        req_wr = 1'b0;
        req_rd = 1'b0;
        if (accepted) begin
            checkOutput("busy_on_accept", busy, 1);
            checkOutput("a_d_on_accept", a_d, 0);
            checkOutput("ad_out_on_accept", ad_out, a);
        end
    endtask

    task automatic waitIdle();
        int guard;
        guard = 0;
        while (cyc < idle_cyc && guard < 300) begin
            @(negedge clk);
            guard++;
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_strobes"}, {cs_n, rd_n, wr_n}, 3'b111);
        checkOutput({tag, "_a_d"}, a_d, 1);
        checkOutput({tag, "_ad_oe"}, ad_oe, 0);
        checkOutput({tag, "_ad_out"}, ad_out, 0);
        checkOutput({tag, "_rdata"}, rdata, 0);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_done"}, done, 0);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            ad_in = ad_hist[cyc % HIST];
        end
    end

    // Monitor: protocol rules every cycle, full transaction check per done.
    initial begin
        int   first_as;
        int   first_ds;
        int   n_addr;
        int   n_as;
        int   n_dw;
        int   n_dr;
        bit   proto_ok;
        exp_t e;
        first_as = -1; first_ds = -1; n_addr = 0; n_as = 0; n_dw = 0; n_dr = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                first_as = -1; first_ds = -1; n_addr = 0; n_as = 0; n_dw = 0; n_dr = 0;
                continue;
            end
            proto_ok = !(!rd_n && !wr_n) && (rd_n || !ad_oe) && (!(rd_n && wr_n) || cs_n);
            checkOutput("protocol", proto_ok, 1);
            if (done) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("done_cycle", cyc, e.done_cyc);
                    checkOutput("rdata_at_done", rdata, e.rdata);
                    checkOutput("busy_at_done", busy, e.busy_after);
                    checkOutput("addr_phase_len", n_addr, PL);
                    checkOutput("addr_strobe_len", n_as, SW);
                    checkOutput("addr_strobe_start", first_as, e.e0 + SS);
                    checkOutput("data_wr_strobes", n_dw, e.is_wr ? SW : 0);
                    checkOutput("data_rd_strobes", n_dr, e.is_wr ? 0 : SW);
                    checkOutput("data_strobe_start", first_ds, e.e0 + PL + SS);
                end
                first_as = -1; first_ds = -1; n_addr = 0; n_as = 0; n_dw = 0; n_dr = 0;
            end
            if (exp_q.size() > 0) begin
                if (!a_d && ad_oe && ad_out == exp_q[0].addr) n_addr++;
                if (!a_d && !cs_n && !wr_n) begin
                    n_as++;
                    if (first_as < 0) first_as = cyc;
                end
                if (a_d && !cs_n && !wr_n && ad_oe && ad_out == exp_q[0].wdata) n_dw++;
                if (a_d && !cs_n && !rd_n && !ad_oe) n_dr++;
                if (a_d && !cs_n && (!wr_n || !rd_n) && first_ds < 0) first_ds = cyc;
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        int e0;
        bit wr;
        bit rd;
        for (int i = 0; i < HIST; i++) ad_hist[i] = 8'($urandom);

        repeat (3) @(negedge clk);
        checkResetOutputs("reset");
        rst = 1'b0;
        idle_cyc = cyc;

        $display("[TB] directed write 0x21 <- 0x59");
        applyStimulus(1'b1, 1'b0, 8'h21, 8'h59);
        waitIdle();

        $display("[TB] directed read 0x22 with bus value 0x14");
        e0 = cyc + 1;
        for (int k = e0 + PL; k < e0 + 2 * PL; k++) ad_hist[k % HIST] = 8'h14;
        applyStimulus(1'b0, 1'b1, 8'h22, 8'h00);
        waitIdle();
        checkOutput("directed_read_value", rdata, 8'h14);

        $display("[TB] simultaneous write+read 0x23 <- 0x07, next request in done cycle");
        applyStimulus(1'b1, 1'b1, 8'h23, 8'h07);
        waitIdle();
        applyStimulus(1'b0, 1'b1, 8'h30, 8'h00);
        repeat (10) @(negedge clk);

        $display("[TB] requests while busy are ignored");
        applyStimulus(1'b0, 1'b1, 8'h44, 8'h00);
        applyStimulus(1'b1, 1'b0, 8'h55, 8'hAA);
        waitIdle();

        $display("[TB] randomized transactions");
        for (int t = 0; t < 24; t++) begin
            waitIdle();
            repeat ($urandom_range(0, 3)) @(negedge clk);
            wr = 1'($urandom_range(0, 1));
            rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
            applyStimulus(wr, rd, 8'($urandom), 8'($urandom));
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 40)) @(negedge clk);
                wr = 1'($urandom_range(0, 1));
                rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
                applyStimulus(wr, rd, 8'($urandom), 8'($urandom));
            end
        end
        waitIdle();

        $display("[TB] reset in the middle of a write");
        n = cyc;
        applyStimulus(1'b1, 1'b0, 8'h66, 8'h99);
        while (cyc < n + 30) @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        checkResetOutputs("midreset");
        @(negedge clk);
        rst = 1'b0;
        idle_cyc = cyc;
        last_rd = 8'd0;
        applyStimulus(1'b1, 1'b1, 8'h77, 8'h3C);
        waitIdle();

        repeat (5) @(negedge clk);
        checkOutput("queue_drained", exp_q.size(), 0);
        checkOutput("idle_busy_low", busy, 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/rtc_bus_sequencer.md
# rtc_bus_sequencer

Sequencer for the multiplexed address/data bus of the real-time-clock chip. Accepts single-cycle read or write requests, runs an address phase, then a data phase, then a recovery gap. A 5-bit phase counter times every phase and generates the chip strobes (`cs_n`, `rd_n`, `wr_n`, `a_d`) and the pad output enable. It sits between the clock/alarm control FSM and the bus pads, and is the only block that drives the RTC bus.

## Interface
- `PHASE_LEN`, 24: cycles per address phase and per data phase. Legal range 12..31.
- `RD_SAMPLE`, 18: counter value in the read data phase at which `ad_in` is latched. Must lie in the strobe window.
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `req_wr`  in  1  one-cycle write request.
- `req_rd`  in  1  one-cycle read request.
- `addr`  in  8  register address; sampled with the accepted request.
- `wdata`  in  8  write data; sampled with the accepted request.
- `ad_in`  in  8  bus value from the pads.
- `ad_out`  out  8  bus value to the pads.
- `ad_oe`  out  1  pad output enable; 1 = block drives the bus.
- `a_d`  out  1  0 = address phase, 1 = data phase or idle.
- `cs_n`, `rd_n`, `wr_n`  out  1 each  active-low chip strobes.
- `rdata`  out  8  last read result; holds until the next read completes.
- `busy`  out  1  high while a transaction is accepted or pending.
- `done`  out  1  one-cycle pulse at the end of each transaction.

## Operation
- States: IDLE, ADDR, DATA_WR, DATA_RD, RECOV.
- Phase counter `cnt` (5 bits):
  - Cleared on every state entry.
  - Increments every cycle inside a phase.
  - Saturates at `PHASE_LEN-1`. That value is the last cycle of the phase.
- Strobe window: `cnt` in [4, `PHASE_LEN-5`] inclusive. Default is 4..19, i.e. 16 cycles.
- IDLE:
  - Strobes high, `a_d`=1, `ad_oe`=0.
  - A request latches `addr`, `wdata` and the operation, then moves to ADDR.
- Arbitration:
  - `req_wr` and `req_rd` in the same IDLE cycle: the write wins. `rd_pending` is set, giving a read-back of the same `addr` after the write.
  - Requests arriving while `busy`=1 are ignored.
- ADDR:
  - `a_d`=0, `ad_oe`=1, `ad_out`=latched addr for the whole phase.
  - `cs_n`=0 and `wr_n`=0 inside the strobe window.
  - Exits to DATA_WR or DATA_RD at `cnt`=`PHASE_LEN-1`.
- DATA_WR:
  - `a_d`=1, `ad_oe`=1, `ad_out`=latched wdata.
  - `cs_n`=0 and `wr_n`=0 in the window.
- DATA_RD:
  - `a_d`=1, `ad_oe`=0.
  - `cs_n`=0 and `rd_n`=0 in the window.
  - `rdata` <= `ad_in` at `cnt`=`RD_SAMPLE`.
- RECOV:
  - Lasts 4 cycles with strobes high and `ad_oe`=0.
  - Exits to ADDR (read, clearing `rd_pending`) if `rd_pending`=1, otherwise to IDLE.
- `rd_n` and `wr_n` are never low in the same cycle. `cs_n` is high whenever both are high.
- Reset values: `cs_n`=`rd_n`=`wr_n`=1, `a_d`=1, `ad_oe`=0, `ad_out`=0, `rdata`=0, `busy`=0, `done`=0, `cnt`=0, state IDLE, `rd_pending`=0.

## Timing
- All outputs are registered. Strobes change only on `clk` edges, with no combinational path from request to pad.
- A request sampled at edge E0 gives:
  - ADDR during cycles E0+1..E0+24.
  - Data phase during E0+25..E0+48.
  - RECOV during E0+49..E0+52.
  - `done`=1 and `busy`=0 for the cycle after edge E0+53, with default parameters.
- `busy` rises on the edge that accepts the request.
- With read-back chained:
  - `done` pulses after the write's RECOV while the read's ADDR starts, and `busy` stays high.
  - A second `done` follows 52 cycles later.
- `rdata` is valid from the edge after `cnt`=`RD_SAMPLE` and is stable when `done` pulses.
- Reset mid-transaction: on the next edge all outputs take their reset values and `rd_pending` clears. No `done` is issued for the aborted transaction.
- A new request is accepted in the same cycle that `done` is high, because the state is IDLE.

## Structure
- Package `rtc_bus_pkg` holds:
  - the state enum;
  - `STROBE_START`=4, `STROBE_END_MARGIN`=4, `RECOV_LEN`=4;
  - the operation encoding (OP_WR=1, OP_RD=0).
- Sub-module `rtc_phase_counter`:
  - 5-bit clear/increment/saturate counter with `clr`, `en` and `limit` inputs.
  - Outputs `cnt` and `last`.
  - Instantiated once.

## Test plan
- Write: `req_wr` with addr=0x21, wdata=0x59 → `a_d`=0 and `ad_out`=0x21 for 24 cycles, then `ad_out`=0x59 with `wr_n` low for cycles 4..19 of the data phase, `done` at E0+53.
- Read: `req_rd` with addr=0x22, bench drives `ad_in`=0x14 during the data phase → `rd_n` low for 16 cycles, `ad_oe`=0 in the data phase, `rdata`=0x14 at `done`.
- Simultaneous `req_wr`+`req_rd`, addr=0x23, wdata=0x07 → write completes, then the read of 0x23 runs with no IDLE gap; two `done` pulses 52 cycles apart; `busy` continuous.
- `req_rd` pulsed while `busy` → ignored: no extra transaction and `rdata` unchanged.
- `rst` asserted at cycle 30 of a write → next edge: strobes high, `ad_oe`=0, `busy`=0, no `done`; a fresh request then runs normally.
- Protocol checker over all tests: never `rd_n`=`wr_n`=0 together, and `ad_oe`=0 whenever `rd_n`=0.
